// File: rtl/sphere_hit_seq.sv
// sphere_hit_seq: sequential ray/sphere nearest-root intersection.
//
// A request is captured on the accept edge. The unit then forms
// Oc = Orig - Center, the quadratic terms a, half_b and c, and the
// discriminant. It takes a restoring square root of the discriminant and a
// restoring divide to reach root = (-half_b - sqrt(discr)) / a. The root is
// range-checked against [t_min, t_max], and the result is held until it is
// accepted.
//
// Ports:
//   clk, reset                synchronous active-high reset
//   in_valid / in_ready       request handshake (in_ready high only in IDLE)
//   r, sphere, color, pi, st  ray, sphere geometry and hit attributes
//   t_min, t_max              inclusive accepted range for T
//   out_valid / out_ready     result handshake (result held until accepted)
//   hit_data                  HitData result
//   busy                      high whenever the unit is not IDLE
//
// Build option: define SPHERE_FAR_ROOT_EN to retry with the far root
// (-half_b + sqrt(discr)) / a when the near root is out of range.

`ifndef FIXED_WIDTH
`define FIXED_WIDTH 32
`endif
`ifndef PRIMITIVE_INDEX
`define PRIMITIVE_INDEX logic [15:0]
`endif

package sphere_hit_pkg;
  typedef logic signed [`FIXED_WIDTH-1:0] Fixed;
  typedef struct packed { Fixed X; Fixed Y; Fixed Z; } Vec3;
  typedef struct packed { Vec3 Orig; Vec3 Dir; `PRIMITIVE_INDEX PI; } Ray;
  typedef struct packed { Vec3 Center; Fixed Radius; } Sphere;
  typedef struct packed { logic [7:0] R; logic [7:0] G; logic [7:0] B; } RGB8;
  typedef enum logic [1:0] {ST_None, ST_Lambertian, ST_Metal, ST_Dielectric} SurfaceType_t;
  typedef struct packed {
    logic            bHit;
    `PRIMITIVE_INDEX PI;
    RGB8             Color;
    SurfaceType_t    SurfaceType;
    Fixed            T;
    Vec3             Normal;
  } HitData;

  localparam `PRIMITIVE_INDEX NULL_PRIMITIVE_INDEX = '1;

  function automatic logic IsValidPrimitiveIndex(input `PRIMITIVE_INDEX idx);
    return idx != NULL_PRIMITIVE_INDEX;
  endfunction

  function automatic HitData miss_hit();
    HitData h;
    h             = '0;
    h.PI          = NULL_PRIMITIVE_INDEX;
    h.SurfaceType = ST_None;
    return h;
  endfunction
endpackage

module sphere_hit_seq
  import sphere_hit_pkg::*;
#(
  parameter int W          = 32,
  parameter int FRAC       = 16,
  parameter bit CHECK_SELF = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  Ray              r,
  input  Sphere           sphere,
  input  RGB8             color,
  input  `PRIMITIVE_INDEX pi,
  input  SurfaceType_t    st,
  input  Fixed            t_min,
  input  Fixed            t_max,
  output logic            out_valid,
  input  logic            out_ready,
  output HitData          hit_data,
  output logic            busy
);

`ifdef SPHERE_FAR_ROOT_EN
  localparam bit FAR_EN = 1'b1;
`else
  localparam bit FAR_EN = 1'b0;
`endif

  localparam int S  = (W + FRAC) / 2;  // square-root result bits
  localparam int D  = W + FRAC;        // dividend / quotient bits
  localparam int SR = S + 3;           // sqrt remainder width
  localparam int RW = W + 1;           // divide remainder width
  localparam int CW = $clog2(D);
  localparam logic [CW-1:0] S_LAST = CW'(S - 1);
  localparam logic [CW-1:0] D_LAST = CW'(D - 1);
  localparam logic signed [W-1:0] FX_ONE = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, PROD, DISCR, SQRT, DIV, CHECK, DONE} state_t;

  // Fixed-point multiply: full 2W product, arithmetic shift, wrap to W bits.
  function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] x,
                                               input logic signed [W-1:0] y);
    logic signed [2*W-1:0] p;
    p = x * y;
    p = p >>> FRAC;
    return p[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] dot(input Vec3 u, input Vec3 v);
    return fmul(u.X, v.X) + fmul(u.Y, v.Y) + fmul(u.Z, v.Z);
  endfunction

  state_t                state;
  logic                  discr_phase;  // DISCR: 0 = form products, 1 = decide
  logic                  far_pass;
  logic [CW-1:0]         cnt;

  Ray                    r_q;
  Sphere                 sph_q;
  RGB8                   color_q;
  logic [$bits(pi)-1:0]  pi_q;
  SurfaceType_t          st_q;
  logic signed [W-1:0]   tmin_q, tmax_q;

  Vec3                   oc;
  logic signed [W-1:0]   a_q, half_b_q, c_q, hb2_q, ac_q;
  logic [D-1:0]          rad_q;        // discriminant radicand, shifted out MSB-first
  logic [SR-1:0]         sq_rem;
  logic [S-1:0]          sq_root;
  logic [W-1:0]          sqrtd_q;
  logic [D-1:0]          dividend;
  logic [RW-1:0]         div_rem;
  logic [D-1:0]          quot;
  logic                  num_neg;

  logic [SR-1:0]         sq_rem_t, sq_trial, sq_rem_n;
  logic                  sq_ge;
  logic [S-1:0]          sq_root_n;
  logic [W-1:0]          sqrtd_n;
  logic signed [W-1:0]   near_num, far_num, div_num;
  logic [W-1:0]          div_mag;
  logic [RW-1:0]         div_rem_t, div_rem_n;
  logic                  div_ge;
  logic [D-1:0]          quot_n;
  logic signed [W-1:0]   root, discr_n;
  logic                  in_range, reject;

  // NOTE: every signal is assigned unconditionally here, so no latches can be inferred.
  always_comb begin
    sq_rem_t  = (sq_rem << 2) | SR'(rad_q[D-1 -: 2]);
    sq_trial  = SR'({sq_root, 2'b01});
    sq_ge     = sq_rem_t >= sq_trial;
    sq_rem_n  = sq_ge ? sq_rem_t - sq_trial : sq_rem_t;
    sq_root_n = (sq_root << 1) | S'(sq_ge);
    sqrtd_n   = {{(W-S){1'b0}}, sq_root_n};

    near_num  = -half_b_q - sqrtd_n;
    far_num   = -half_b_q + sqrtd_q;
    // The near root is loaded on the last SQRT cycle; the far root on a CHECK retry.
    div_num   = (state == SQRT) ? near_num : far_num;
    div_mag   = div_num[W-1] ? -div_num : div_num;

    div_rem_t = (div_rem << 1) | RW'(dividend[D-1]);
    div_ge    = div_rem_t >= {1'b0, a_q};
    div_rem_n = div_ge ? div_rem_t - {1'b0, a_q} : div_rem_t;
    quot_n    = (quot << 1) | D'(div_ge);

    root      = num_neg ? -$signed(quot[W-1:0]) : $signed(quot[W-1:0]);
    in_range  = (root >= tmin_q) && (root <= tmax_q);

    discr_n   = hb2_q - ac_q;
    reject    = discr_n[W-1] || (a_q == '0) || !IsValidPrimitiveIndex(pi_q) ||
                (CHECK_SELF && (r_q.PI == pi_q));
  end

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  // NOTE: datapath registers are not reset; they are always loaded before they are read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      discr_phase <= 1'b0;
      far_pass    <= 1'b0;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      hit_data    <= miss_hit();
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_q      <= r;
            sph_q    <= sphere;
            color_q  <= color;
            pi_q     <= pi;
            st_q     <= st;
            tmin_q   <= t_min;
            tmax_q   <= t_max;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end
        PREP: begin
          oc.X  <= r_q.Orig.X - sph_q.Center.X;
          oc.Y  <= r_q.Orig.Y - sph_q.Center.Y;
          oc.Z  <= r_q.Orig.Z - sph_q.Center.Z;
          state <= PROD;
        end
        PROD: begin
          a_q      <= dot(r_q.Dir, r_q.Dir);
          half_b_q <= dot(oc, r_q.Dir);
          c_q      <= dot(oc, oc) - fmul(sph_q.Radius, sph_q.Radius);
          state    <= DISCR;
        end
        DISCR: begin
          if (!discr_phase) begin
            hb2_q       <= fmul(half_b_q, half_b_q);
            ac_q        <= fmul(a_q, c_q);
            discr_phase <= 1'b1;
          end else begin
            discr_phase <= 1'b0;
            rad_q       <= {discr_n, {FRAC{1'b0}}};
            sq_rem      <= '0;
            sq_root     <= '0;
            cnt         <= '0;
            if (reject) begin
              hit_data  <= miss_hit();
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state     <= SQRT;
            end
          end
        end
        SQRT: begin
          sq_rem  <= sq_rem_n;
          sq_root <= sq_root_n;
          rad_q   <= rad_q << 2;
          cnt     <= cnt + 1'b1;
          if (cnt == S_LAST) begin
            sqrtd_q  <= sqrtd_n;
            dividend <= {div_mag, {FRAC{1'b0}}};
            div_rem  <= '0;
            quot     <= '0;
            num_neg  <= div_num[W-1];
            far_pass <= 1'b0;
            cnt      <= '0;
            state    <= DIV;
          end
        end
        DIV: begin
          div_rem  <= div_rem_n;
          quot     <= quot_n;
          dividend <= dividend << 1;
          cnt      <= cnt + 1'b1;
          if (cnt == D_LAST) begin
            cnt   <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (in_range) begin
            hit_data  <= '{bHit: 1'b1, PI: pi_q, Color: color_q, SurfaceType: st_q,
                           T: root, Normal: '{X: '0, Y: FX_ONE, Z: '0}};
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (FAR_EN && !far_pass) begin
            dividend <= {div_mag, {FRAC{1'b0}}};
            div_rem  <= '0;
            quot     <= '0;
            num_neg  <= div_num[W-1];
            far_pass <= 1'b1;
            state    <= DIV;
          end else begin
            hit_data  <= miss_hit();
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sphere_hit_seq.sv
// Testbench for sphere_hit_seq: a hand-computed vector table, handshake and
// reset sequences, and randomized transactions compared against a plain
// integer-arithmetic model of the intersection.
module tb_sphere_hit_seq;
  import sphere_hit_pkg::*;

  localparam int F = 65536;  // 1.0 in Q16.16
`ifdef SPHERE_FAR_ROOT_EN
  localparam int FAR = 1;
`else
  localparam int FAR = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  Ray           r;
  Sphere        sphere;
  RGB8          color;
  logic [15:0]  pi;
  SurfaceType_t st;
  Fixed         t_min, t_max;
  HitData       hit_data;

  int n_checks = 0;
  int n_errors = 0;

  sphere_hit_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .r(r), .sphere(sphere), .color(color), .pi(pi), .st(st),
    .t_min(t_min), .t_max(t_max), .out_valid(out_valid), .out_ready(out_ready),
    .hit_data(hit_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int ox, oy, oz, dx, dy, dz, cx, cy, cz, rad, tmin, tmax;
    logic [15:0] rpi, pi;
  } txn_t;

  typedef struct {
    txn_t t;
    logic hit;
    int   tval;
    int   lat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fx_mul(input int a, input int b);
    return int'((longint'(a) * longint'(b)) >>> 16);
  endfunction

  function automatic longint isqrt(input longint v);
    longint s;
    s = longint'($sqrt(real'(v)));
    while (s * s > v) s--;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  function automatic void model(input txn_t t, output logic hit, output int tval, output int lat);
    int ocx, ocy, ocz, a, hb, c, discr, s, num, q32, root;
    longint unsigned mag, au, q;
    hit = 1'b0; tval = 0; lat = 4;
    ocx = t.ox - t.cx; ocy = t.oy - t.cy; ocz = t.oz - t.cz;
    a  = fx_mul(t.dx, t.dx) + fx_mul(t.dy, t.dy) + fx_mul(t.dz, t.dz);
    hb = fx_mul(ocx, t.dx) + fx_mul(ocy, t.dy) + fx_mul(ocz, t.dz);
    c  = fx_mul(ocx, ocx) + fx_mul(ocy, ocy) + fx_mul(ocz, ocz) - fx_mul(t.rad, t.rad);
    discr = fx_mul(hb, hb) - fx_mul(a, c);
    if (discr < 0 || a == 0 || t.pi == 16'hFFFF || t.rpi == t.pi) return;
    s  = int'(isqrt(longint'(discr) * 65536));
    au = {32'd0, a};
    for (int pass = 0; pass <= FAR; pass++) begin
      lat  = 77 + 49 * pass;
      num  = (pass == 0) ? -hb - s : -hb + s;
      mag  = (num < 0) ? -longint'(num) : longint'(num);
      q    = (mag << 16) / au;
      q32  = int'(q);
      root = (num < 0) ? -q32 : q32;
      if (root >= t.tmin && root <= t.tmax) begin
        hit = 1'b1; tval = root;
        return;
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic start_txn(input txn_t t);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_accept", in_ready, 1);
    r.Orig.X = t.ox; r.Orig.Y = t.oy; r.Orig.Z = t.oz;
    r.Dir.X  = t.dx; r.Dir.Y  = t.dy; r.Dir.Z  = t.dz;
    r.PI     = t.rpi;
    sphere.Center.X = t.cx; sphere.Center.Y = t.cy; sphere.Center.Z = t.cz;
    sphere.Radius   = t.rad;
    pi    = t.pi;
    t_min = t.tmin;
    t_max = t.tmax;
    color = RGB8'($urandom);
    st    = SurfaceType_t'($urandom_range(1, 3));
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic verify(input string tag, input logic eh, input int et, input int el, input int lat);
    check({tag, "_lat"}, lat, el);
    check({tag, "_hit"}, hit_data.bHit, eh);
    check({tag, "_T"}, hit_data.T, eh ? et : 0);
    check({tag, "_PI"}, hit_data.PI, eh ? pi : 16'hFFFF);
    check({tag, "_st"}, int'(hit_data.SurfaceType), eh ? int'(st) : int'(ST_None));
    if (eh) begin
      check({tag, "_color"}, hit_data.Color, color);
      check({tag, "_normal_y"}, hit_data.Normal.Y, F);
    end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_release", in_ready, 1);
    check("out_valid_after_release", out_valid, 0);
  endtask

  function automatic txn_t base_txn();
    txn_t t;
    t = '{ox: 0, oy: 0, oz: -5 * F, dx: 0, dy: 0, dz: F, cx: 0, cy: 0, cz: 0,
          rad: F, tmin: 0, tmax: 100 * F, rpi: 16'd1, pi: 16'd2};
    return t;
  endfunction

  vec_t vecs[9];

  initial begin
    int    lat, hold, ov_seen;
    txn_t  t;
    logic  eh;
    int    et, el;
    HitData hd0;
    logic  stable_ok;

    // Vector table, expectations worked out by hand.
    vecs[0].t = base_txn();                                 vecs[0].hit = 1; vecs[0].tval = 4 * F; vecs[0].lat = 77;
    vecs[1].t = base_txn(); vecs[1].t.oy = 2 * F;           vecs[1].hit = 0; vecs[1].tval = 0;     vecs[1].lat = 4;
    vecs[2].t = base_txn(); vecs[2].t.oz = 0; vecs[2].t.tmin = 66;
    vecs[2].hit = FAR[0]; vecs[2].tval = FAR ? F : 0; vecs[2].lat = FAR ? 126 : 77;
    vecs[3].t = base_txn(); vecs[3].t.pi = 16'd1;           vecs[3].hit = 0; vecs[3].tval = 0;     vecs[3].lat = 4;
    vecs[4].t = base_txn(); vecs[4].t.dz = 0;               vecs[4].hit = 0; vecs[4].tval = 0;     vecs[4].lat = 4;
    vecs[5].t = base_txn(); vecs[5].t.tmax = 3 * F;
    vecs[5].hit = 0; vecs[5].tval = 0; vecs[5].lat = FAR ? 126 : 77;
    vecs[6].t = base_txn(); vecs[6].t.pi = 16'hFFFF;        vecs[6].hit = 0; vecs[6].tval = 0;     vecs[6].lat = 4;
    vecs[7].t = base_txn(); vecs[7].t.tmin = 4 * F; vecs[7].t.tmax = 4 * F;
    vecs[7].hit = 1; vecs[7].tval = 4 * F; vecs[7].lat = 77;
    vecs[8].t = base_txn(); vecs[8].t.tmin = 4 * F + 1;
    vecs[8].hit = FAR[0]; vecs[8].tval = FAR ? 6 * F : 0; vecs[8].lat = FAR ? 126 : 77;

    // Reset state
    r = '0; sphere = '0; color = '0; pi = '0; st = ST_None; t_min = '0; t_max = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_hit", hit_data.bHit, 0);
    check("rst_PI", hit_data.PI, 16'hFFFF);
    check("rst_T", hit_data.T, 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven vectors
    foreach (vecs[i]) begin
      start_txn(vecs[i].t);
      wait_out(lat);
      verify($sformatf("vec%0d", i), vecs[i].hit, vecs[i].tval, vecs[i].lat, lat);
      release_out(0);
    end

    // Back-pressure: result held for 10 cycles, no accept in the release cycle
    start_txn(base_txn());
    wait_out(lat);
    verify("hold", 1'b1, 4 * F, 77, lat);
    hd0 = hit_data;
    stable_ok = 1'b1;
    in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (hit_data !== hd0 || !out_valid || in_ready) stable_ok = 1'b0;
    end
    check("hold_stable", stable_ok, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("hold_idle_in_ready", in_ready, 1);
    check("hold_no_accept_busy", busy, 0);
    @(negedge clk);

    // Reset in the 10th SQRT cycle
    start_txn(base_txn());
    repeat (13) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    ov_seen = 0;
    repeat (150) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("midrst_no_out_valid", ov_seen, 0);
    start_txn(base_txn());
    wait_out(lat);
    verify("after_rst", 1'b1, 4 * F, 77, lat);
    release_out(0);

    // Randomized transactions against the model
    for (int k = 0; k < 40; k++) begin
      t.ox = int'($urandom_range(0, 16 * F)) - 8 * F;
      t.oy = int'($urandom_range(0, 16 * F)) - 8 * F;
      t.oz = int'($urandom_range(0, 16 * F)) - 8 * F;
      t.dx = int'($urandom_range(0, 4 * F)) - 2 * F;
      t.dy = int'($urandom_range(0, 4 * F)) - 2 * F;
      t.dz = int'($urandom_range(0, 4 * F)) - 2 * F;
      t.cx = int'($urandom_range(0, 8 * F)) - 4 * F;
      t.cy = int'($urandom_range(0, 8 * F)) - 4 * F;
      t.cz = int'($urandom_range(0, 8 * F)) - 4 * F;
      t.rad  = int'($urandom_range(F / 4, 6 * F));
      t.tmin = int'($urandom_range(0, 2 * F)) - F;
      t.tmax = t.tmin + int'($urandom_range(0, 20 * F));
      t.rpi  = 16'($urandom_range(0, 7));
      t.pi   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
      model(t, eh, et, el);
      start_txn(t);
      wait_out(lat);
      verify($sformatf("rnd%0d", k), eh, et, el, lat);
      hold = int'($urandom_range(0, 3));
      release_out(hold);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
